// File: rtl/core_pkg.sv
// Shared core definitions for the writeback/forwarding result path.
// Width rules stay with the instantiating stage.
package core_pkg;

    localparam int XLEN      = 32;
    localparam int WB_NUM_IN = 4;

    localparam int RES_ALU = 0;
    localparam int RES_MEM = 1;
    localparam int RES_PC4 = 2;
    localparam int RES_IMM = 3;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_PC4 = 2'd2,
        SRC_IMM = 2'd3
    } result_src_t;

endpackage

// File: rtl/result_sel_pipe_if.sv
// Handshake and data bundle for the registered result-select stage.
// master drives the inputs, slave is the stage itself.
interface result_sel_pipe_if
    import core_pkg::*;
#(
    parameter int WIDTH     = XLEN,
    parameter int NUM_IN    = WB_NUM_IN,
    parameter int SEL_W     = (NUM_IN > 2) ? $clog2(NUM_IN) : 1,
    parameter int ERR_CNT_W = 8
);

    logic [NUM_IN*WIDTH-1:0] d_flat;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        y;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic [ERR_CNT_W-1:0]    err_cnt;

    modport master (
        output d_flat, sel, in_valid, flush, out_ready,
        input  in_ready, y, out_valid, sel_err, err_cnt
    );

    modport slave (
        input  d_flat, sel, in_valid, flush, out_ready,
        output in_ready, y, out_valid, sel_err, err_cnt
    );

endinterface

// File: rtl/result_sel_pipe_skid_reg.sv
// Two-entry valid/ready buffer: output register plus one skid slot.
// in_ready is registered so it never follows out_ready combinationally.
module skid_reg #(
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          in_ready_q, in_ready_d;
    logic          acc;
    logic          out_empty;

    always_comb begin
        acc          = in_valid && in_ready_q && !flush;
        out_empty    = !out_valid_q || out_ready;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_empty) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (acc) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/result_sel_pipe.sv
// Registered N-way result select with skid buffering, flush and
// a saturating count of out-of-range select indices.
module result_sel_pipe
    import core_pkg::*;
#(
    parameter int WIDTH     = XLEN,
    parameter int NUM_IN    = WB_NUM_IN,
    parameter int SEL_W     = (NUM_IN > 2) ? $clog2(NUM_IN) : 1,
    parameter int ERR_CNT_W = 8
) (
    input logic         clk,
    input logic         reset,
    result_sel_pipe_if.slave bus
);

    logic [WIDTH-1:0]     sel_val;
    logic                 sel_bad;
    logic                 in_ready;
    logic                 out_valid;
    logic [WIDTH:0]       out_word;
    logic                 acc;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Indices past NUM_IN yield zero and are flagged bad.
    always_comb begin
        sel_bad = 1'b1;
        sel_val = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                sel_bad = 1'b0;
                sel_val = bus.d_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        acc       = bus.in_valid && in_ready && !bus.flush;
        err_cnt_d = err_cnt_q;
        if (acc && sel_bad && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    skid_reg #(
        .DW(WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (bus.flush),
        .in_valid (bus.in_valid),
        .in_data  ({sel_bad, sel_val}),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_word),
        .out_ready(bus.out_ready)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.y         = out_word[WIDTH-1:0];
    assign bus.sel_err   = out_word[WIDTH];
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: doc/result_sel_pipe.md
Name: result_sel_pipe

Overview:
- Registered N-way result-select stage for the RISC-V core's writeback/forwarding path. It is the parametrised, pipelined successor of the combinational 3-input select.
- Selects one of NUM_IN data words by an index and registers the result.
- Uses a valid/ready handshake with a one-entry skid buffer, so back-pressure costs no throughput.
- Supports pipeline flush and flags out-of-range selects.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 4, number of data inputs (2..16).
- SEL_W, $clog2(NUM_IN) (min 1), select index width.
- ERR_CNT_W, 8, width of the saturating bad-select counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- d_flat  in  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  in  SEL_W  input index, sampled with in_valid.
- in_valid  in  1  upstream word and sel are valid.
- in_ready  out  1  stage can accept a word this cycle.
- flush  in  1  discard all held words (branch mispredict or trap).
- y  out  WIDTH  selected, registered result.
- out_valid  out  1  y is valid.
- out_ready  in  1  downstream accepts y.
- sel_err  out  1  registered flag: the word currently in y had an out-of-range sel.
- err_cnt  out  ERR_CNT_W  saturating count of accepted out-of-range selects.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. All state updates on the rising edge of clk.
- Reset values: y=0, out_valid=0, sel_err=0, err_cnt=0, skid_valid=0, skid data=0. in_ready=0 while reset is high and 1 on the first cycle after release.
- in_ready is registered: in_ready = !skid_valid (next-state form). It never depends combinationally on out_ready.
- Accept: acc = in_valid && in_ready && !flush.
- Selected value is d_flat[sel] when sel < NUM_IN. Otherwise it is WIDTH'h0 with bad=1. This generalises the 2'b11 -> 0 rule to any non-power-of-two NUM_IN.
- Output register update, taken when out_empty = !out_valid || out_ready:
  - if skid_valid: load y/sel_err from skid and clear skid_valid;
  - else if acc: load y/sel_err from the input path;
  - else: out_valid=0.
- Skid capture: acc while !out_empty writes the input word into the skid (skid_valid=1), and in_ready goes 0 next cycle.
- skid_valid set and out_empty in the same cycle: skid drains to the output. A simultaneous acc is impossible because in_ready=0.
- Latency: 1 cycle from acc to out_valid when unstalled. Throughput is 1 word/cycle under continuous out_ready=1.
- State summary (ELEMENTS = out_valid + skid_valid):
  - EMPTY (0 held): acc -> ONE.
  - ONE: acc && out_ready -> ONE; acc && !out_ready -> FULL; !acc && out_ready -> EMPTY.
  - FULL (2 held): out_ready -> ONE; otherwise stay. in_ready=0.
- Flush: highest priority after reset. Next cycle out_valid=0, skid_valid=0, in_ready=1. The input presented in the flush cycle is dropped. y keeps its last value (don't-care when invalid). err_cnt is not cleared.
- err_cnt increments on acc && bad and saturates at all-ones. A bad word dropped by flush is not counted.
- Order preserved; no word duplicated or lost absent flush.
- Reset asserted mid-stall discards both held words.

Decomposition:
- Shared package core_pkg holds the localparam XLEN=32, the default NUM_IN for writeback (RES_ALU=0, RES_MEM=1, RES_PC4=2, RES_IMM=3) as named constants, and the result_src_t enum. Width rules are owned by the instantiating stage.
- One natural sub-module: skid_reg #(WIDTH+1), a 2-entry valid/ready skid buffer. The combinational index/range-check select stays inline.

Test Plan:
- Reset, then NUM_IN=4, WIDTH=32, d=(0x11,0x22,0x33,0x44), stream sel=0,1,2,3 with out_ready=1 -> y=0x11,0x22,0x33,0x44 on consecutive cycles, first one cycle after acc, in_ready constantly 1.
- NUM_IN=3: sel=3 accepted -> y=0, sel_err=1, err_cnt=1. Repeat 300 times -> err_cnt saturates at 255.
- Hold out_ready=0 and send sel=0 then sel=1 -> y=0x11 held, in_ready=0 after the 2nd accept. Release out_ready -> y=0x22 next cycle, then out_valid=0, in_ready=1.
- FULL state plus flush=1 with in_valid=1, sel=2 -> next cycle out_valid=0, in_ready=1, and 0x33 never appears on y.
- Random in_valid/out_ready for 10k cycles against a reference queue model -> order-exact match, no word lost or duplicated, in_ready never combinationally tracks out_ready.
- Reset asserted while FULL -> next cycle out_valid=0, in_ready=0, err_cnt=0. After release in_ready=1.
